// File: rtl/soc_run_controller.sv
// Run-control sequencer for the core: reset pulse, cycle budget, trap watch,
// optional re-run after a trap, and a registered final status.
module soc_run_controller #(
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32,
  parameter int AUTO_START     = 1,
  parameter int MAX_RETRIES    = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             trap,
  output logic             core_resetn,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       retry_count
);
  localparam int              HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // One above the retry limit so the "retries left" test never compares against zero.
  localparam logic [8:0]      RETRY_LIM = 9'(MAX_RETRIES + 1);

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_TRAP  = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("RST_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1 || (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 1 and < 2**CNT_W");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 255) begin : g_bad_retry
    $error("MAX_RETRIES must be in 0..255");
  end

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [CNT_W-1:0] cyc_nxt;
  logic [7:0]       retry_nxt;
  logic [1:0]       status_nxt;

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    cyc_nxt    = cycle_count;
    retry_nxt  = retry_count;
    status_nxt = status;
    case (state)
      IDLE: begin
        if (AUTO_START != 0 || start) begin
          state_nxt  = HOLD;
          hold_nxt   = '0;
          cyc_nxt    = '0;
          retry_nxt  = '0;
          status_nxt = ST_NONE;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = ST_ABORT;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = ST_ABORT;
        end else if (trap) begin
          if (({1'b0, retry_count} + 9'd1) < RETRY_LIM) begin
            state_nxt = HOLD;
            retry_nxt = retry_count + 8'd1;
            hold_nxt  = '0;
            cyc_nxt   = '0;
          end else begin
            state_nxt  = DONE;
            status_nxt = ST_TRAP;
          end
        end else if (cycle_count == RUN_LAST) begin
          state_nxt  = DONE;
          status_nxt = ST_TMO;
        end else begin
          cyc_nxt = cycle_count + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt  = HOLD;
          hold_nxt   = '0;
          cyc_nxt    = '0;
          retry_nxt  = '0;
          status_nxt = ST_NONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      retry_count <= '0;
      status      <= ST_NONE;
      core_resetn <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      cycle_count <= cyc_nxt;
      retry_count <= retry_nxt;
      status      <= status_nxt;
      core_resetn <= (state_nxt == RUN);
      running     <= (state_nxt == RUN);
      done        <= (state_nxt == DONE);
    end
  end
endmodule

// File: tb/tb_soc_run_controller.sv
// Bench for soc_run_controller: three configurations share clock and reset,
// directed scenarios plus randomized runs checked against a timeline model.
module tb_soc_run_controller;
  localparam int P_RST  [3] = '{2, 3, 2};
  localparam int P_TO   [3] = '{8, 10, 8};
  localparam int P_MR   [3] = '{0, 2, 1};
  localparam int P_AUTO [3] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] start, abort, trap;
  logic [2:0] core_resetn, running, done;
  logic [1:0] status [3];
  logic [15:0] cc [3];
  logic [7:0] rc [3];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  soc_run_controller #(.RST_CYCLES(2), .TIMEOUT_CYCLES(8), .CNT_W(16), .AUTO_START(1), .MAX_RETRIES(0)) u_i0 (
    .clk(clk), .resetn(resetn), .start(start[0]), .abort(abort[0]), .trap(trap[0]),
    .core_resetn(core_resetn[0]), .running(running[0]), .done(done[0]),
    .status(status[0]), .cycle_count(cc[0]), .retry_count(rc[0]));

  soc_run_controller #(.RST_CYCLES(3), .TIMEOUT_CYCLES(10), .CNT_W(16), .AUTO_START(1), .MAX_RETRIES(2)) u_i1 (
    .clk(clk), .resetn(resetn), .start(start[1]), .abort(abort[1]), .trap(trap[1]),
    .core_resetn(core_resetn[1]), .running(running[1]), .done(done[1]),
    .status(status[1]), .cycle_count(cc[1]), .retry_count(rc[1]));

  soc_run_controller #(.RST_CYCLES(2), .TIMEOUT_CYCLES(8), .CNT_W(16), .AUTO_START(0), .MAX_RETRIES(1)) u_i2 (
    .clk(clk), .resetn(resetn), .start(start[2]), .abort(abort[2]), .trap(trap[2]),
    .core_resetn(core_resetn[2]), .running(running[2]), .done(done[2]),
    .status(status[2]), .cycle_count(cc[2]), .retry_count(rc[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves resetn released just after "edge 0"; edge 1 is the first active edge.
  task automatic do_reset();
    resetn = 1'b0;
    start = '0;
    abort = '0;
    trap = '0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = '0;
    abort = '0;
    trap = '0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({core_resetn[i], running[i], done[i]} !== 3'b000) begin
        errs++; $display("FAIL reset flags i%0d: got %b exp 000", i, {core_resetn[i], running[i], done[i]});
      end
      checks++;
      if (status[i] !== 2'b00 || cc[i] !== 16'd0 || rc[i] !== 8'd0) begin
        errs++; $display("FAIL reset counters i%0d: status %b cc %0d rc %0d exp 0", i, status[i], cc[i], rc[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic xc, xd;
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      tick();
      xc = (e >= 3 && e < 11);
      xd = (e >= 11);
      checks++;
      if (core_resetn[0] !== xc) begin errs++; $display("FAIL tmo core_resetn e%0d: got %b exp %b", e, core_resetn[0], xc); end
      checks++;
      if (done[0] !== xd) begin errs++; $display("FAIL tmo done e%0d: got %b exp %b", e, done[0], xd); end
      if (xc) begin
        checks++;
        if (cc[0] !== 16'(e - 3)) begin errs++; $display("FAIL tmo cycle_count e%0d: got %0d exp %0d", e, cc[0], e - 3); end
      end
    end
    checks++;
    if (status[0] !== 2'b10) begin errs++; $display("FAIL tmo status: got %b exp 10", status[0]); end
    checks++;
    if (cc[0] !== 16'd7) begin errs++; $display("FAIL tmo final cycle_count: got %0d exp 7", cc[0]); end
  endtask

  task automatic test_trap();
    logic xc, xd;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      trap[0] = (e == 7);
      xc = (e >= 3 && e < 8);
      xd = (e >= 8);
      checks++;
      if (core_resetn[0] !== xc) begin errs++; $display("FAIL trap core_resetn e%0d: got %b exp %b", e, core_resetn[0], xc); end
      checks++;
      if (done[0] !== xd) begin errs++; $display("FAIL trap done e%0d: got %b exp %b", e, done[0], xd); end
    end
    checks++;
    if (status[0] !== 2'b01 || cc[0] !== 16'd4) begin
      errs++; $display("FAIL trap result: status %b cc %0d exp 01/4", status[0], cc[0]);
    end
  endtask

  task automatic test_retry();
    logic xc, xd;
    int xr;
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      tick();
      trap[1] = (e == 7 || e == 14 || e == 21);
      xc = (e >= 4 && e < 8) || (e >= 11 && e < 15) || (e >= 18 && e < 22);
      xd = (e >= 22);
      xr = (e >= 15) ? 2 : (e >= 8) ? 1 : 0;
      checks++;
      if (core_resetn[1] !== xc) begin errs++; $display("FAIL retry core_resetn e%0d: got %b exp %b", e, core_resetn[1], xc); end
      checks++;
      if (done[1] !== xd || rc[1] !== 8'(xr)) begin
        errs++; $display("FAIL retry done/rc e%0d: got %b/%0d exp %b/%0d", e, done[1], rc[1], xd, xr);
      end
    end
    checks++;
    if (status[1] !== 2'b01 || cc[1] !== 16'd3 || rc[1] !== 8'd2) begin
      errs++; $display("FAIL retry result: status %b cc %0d rc %0d exp 01/3/2", status[1], cc[1], rc[1]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick();
      abort[0] = (e == 5);
      trap[0] = (e == 5);
      checks++;
      if (done[0] !== (e >= 6)) begin errs++; $display("FAIL abort_run done e%0d: got %b", e, done[0]); end
    end
    checks++;
    if (status[0] !== 2'b11 || cc[0] !== 16'd2) begin
      errs++; $display("FAIL abort_run result: status %b cc %0d exp 11/2", status[0], cc[0]);
    end
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      abort[0] = (e == 1);
      checks++;
      if (core_resetn[0] !== 1'b0 || done[0] !== (e >= 2)) begin
        errs++; $display("FAIL abort_hold e%0d: core_resetn %b done %b", e, core_resetn[0], done[0]);
      end
    end
    checks++;
    if (status[0] !== 2'b11) begin errs++; $display("FAIL abort_hold status: got %b exp 11", status[0]); end
  endtask

  task automatic test_manual_start();
    logic xc, xd;
    logic [1:0] xs;
    int xr;
    do_reset();
    for (int e = 1; e <= 52; e++) begin
      tick();
      start[2] = (e == 20 || e == 26 || e == 35);
      trap[2] = (e == 38);
      xc = (e >= 23 && e < 31) || (e == 38) || (e >= 41 && e < 49);
      xd = (e >= 31 && e < 36) || (e >= 49);
      xs = xd ? 2'b10 : 2'b00;
      xr = (e >= 39) ? 1 : 0;
      checks++;
      if (core_resetn[2] !== xc || running[2] !== xc) begin
        errs++; $display("FAIL manual core_resetn/running e%0d: got %b/%b exp %b", e, core_resetn[2], running[2], xc);
      end
      checks++;
      if (done[2] !== xd || status[2] !== xs || rc[2] !== 8'(xr)) begin
        errs++; $display("FAIL manual done/status/rc e%0d: got %b/%b/%0d exp %b/%b/%0d", e, done[2], status[2], rc[2], xd, xs, xr);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (6) tick();
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({core_resetn[i], running[i], done[i]} !== 3'b000 || status[i] !== 2'b00 || cc[i] !== 16'd0 || rc[i] !== 8'd0) begin
        errs++; $display("FAIL async_reset i%0d: flags %b status %b cc %0d rc %0d", i,
                         {core_resetn[i], running[i], done[i]}, status[i], cc[i], rc[i]);
      end
    end
    tick();
    resetn = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (core_resetn[0] !== (e >= 3)) begin errs++; $display("FAIL async_restart e%0d: core_resetn %b", e, core_resetn[0]); end
    end
  endtask

  // Randomized runs: the expected timeline is built up front as a list of
  // attempts (hold edge, run edge) and a final end edge/status.
  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int id, rst, to, mr, na, ab, st0, en, kind, last, ccf;
      int s [4];
      int r [4];
      int tr [4];
      bit hn, sn, fin, t;
      id = it % 3;
      rst = P_RST[id]; to = P_TO[id]; mr = P_MR[id];
      for (int a = 0; a < 4; a++) begin
        tr[a] = int'($urandom_range(0, to + to / 2));
        s[a] = 0; r[a] = 0;
      end
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1;
      st0 = (P_AUTO[id] != 0) ? 0 : int'($urandom_range(1, 5));
      hn = 1'($urandom_range(0, 1));
      sn = 1'($urandom_range(0, 1));
      s[0] = st0 + 1;
      na = 0; en = 0; kind = 0; fin = 0;
      for (int a = 0; a <= mr && !fin; a++) begin
        int et, eto;
        r[a] = s[a] + rst;
        na = a + 1;
        eto = r[a] + to;
        et = (tr[a] < to) ? r[a] + tr[a] + 1 : eto + 1;
        if (ab >= 0 && ab + 1 > s[a] && ab + 1 <= et && ab + 1 <= eto) begin
          en = ab + 1; kind = 3; fin = 1;
        end else if (tr[a] < to) begin
          if (a < mr) s[a + 1] = et;
          else begin en = et; kind = 1; fin = 1; end
        end else begin
          en = eto; kind = 2; fin = 1;
        end
      end
      last = na - 1;
      ccf = (en > r[last]) ? en - r[last] - 1 : 0;

      do_reset();
      for (int e = 1; e <= en + 2; e++) begin
        int a, xcc, xrc;
        logic xc, xd;
        logic [1:0] xs;
        tick();
        start[id] = (e == st0) || (sn && e == en - 1);
        abort[id] = (e == ab);
        t = 0;
        for (int b = 0; b < na; b++)
          if (e == r[b] + tr[b] || (hn && e >= s[b] && e < r[b])) t = 1;
        trap[id] = t;

        a = -1;
        for (int b = 0; b < na; b++) if (s[b] <= e) a = b;
        xc = 0; xd = 0; xs = 2'b00; xcc = 0; xrc = 0;
        if (e >= en) begin
          xd = 1; xs = 2'(kind); xcc = ccf; xrc = last;
        end else if (a >= 0) begin
          xrc = a;
          if (e >= r[a]) begin xc = 1; xcc = e - r[a]; end
        end
        checks++;
        if (core_resetn[id] !== xc || running[id] !== xc) begin
          errs++; $display("FAIL rnd%0d i%0d e%0d core_resetn/running: got %b/%b exp %b", it, id, e, core_resetn[id], running[id], xc);
        end
        checks++;
        if (done[id] !== xd || status[id] !== xs) begin
          errs++; $display("FAIL rnd%0d i%0d e%0d done/status: got %b/%b exp %b/%b", it, id, e, done[id], status[id], xd, xs);
        end
        checks++;
        if (cc[id] !== 16'(xcc) || rc[id] !== 8'(xrc)) begin
          errs++; $display("FAIL rnd%0d i%0d e%0d cc/rc: got %0d/%0d exp %0d/%0d", it, id, e, cc[id], rc[id], xcc, xrc);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timeout();
    test_trap();
    test_retry();
    test_abort();
    test_manual_start();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/soc_run_controller.md
Name: soc_run_controller

Overview:
- Synthesizable run-control sequencer that sits between the board/bench reset and the AISoc core.
- Generates the core reset pulse, enforces a cycle budget and watches the core `trap` line.
- Reports pass/trap/timeout/abort status, with optional automatic re-run after a trap.
- Replaces the hard-coded reset-pulse/finish-timer pattern with a parametrised, reusable block usable both on FPGA and in simulation.

Parameters:
- RST_CYCLES, 2: cycles `core_resetn` is held low per attempt (>=1).
- TIMEOUT_CYCLES, 1000: RUN cycles allowed per attempt before timeout (>=1, < 2^CNT_W).
- CNT_W, 32: width of `cycle_count`.
- AUTO_START, 1: 1 = begin a run automatically after `resetn` release; 0 = wait for `start`.
- MAX_RETRIES, 0: automatic re-runs after a trap before reporting trap (0..255).

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- start, input, 1: start request; sampled only in IDLE or DONE.
- abort, input, 1: terminate the current attempt; sampled in HOLD or RUN.
- trap, input, 1: core trap indication; sampled only in RUN.
- core_resetn, output, 1: registered active-low reset to the core.
- running, output, 1: high while in RUN.
- done, output, 1: high while in DONE.
- status, output, 2: final result. 00 none, 01 trap, 10 timeout, 11 aborted.
- cycle_count, output, CNT_W: RUN cycles elapsed in the current attempt.
- retry_count, output, 8: automatic re-runs performed since the last start.

Behaviour:
- All outputs registered.
- Reset (async, `resetn`=0):
  - state IDLE, `core_resetn`=0, `running`=0, `done`=0.
  - `status`=00, `cycle_count`=0, `retry_count`=0.
  - Internal hold counter = 0.
- States: IDLE, HOLD, RUN, DONE. `core_resetn`=1 only in RUN.
- IDLE:
  - Moves to HOLD on the first edge after reset release if AUTO_START=1.
  - Otherwise moves to HOLD on the edge sampling `start`=1.
- HOLD:
  - `core_resetn`=0.
  - Hold counter counts 0..RST_CYCLES-1; RUN is entered on the edge after the last count.
  - HOLD therefore lasts exactly RST_CYCLES cycles.
  - `trap` is ignored in HOLD.
- RUN:
  - `core_resetn`=1 and `running`=1 from the entry edge.
  - `cycle_count`=0 in the first RUN cycle, then +1 per cycle.
  - Trap (`trap`=1 sampled at an edge in RUN):
    - If `retry_count` < MAX_RETRIES: increment `retry_count`, go to HOLD (`core_resetn`=0 from the same edge).
    - Otherwise go to DONE with `status`=01.
  - Timeout: when `cycle_count`==TIMEOUT_CYCLES-1 and no trap is sampled, go to DONE with `status`=10 on that edge. The core therefore runs exactly TIMEOUT_CYCLES cycles.
  - `cycle_count` is frozen on leaving RUN and cleared to 0 on entering HOLD.
- DONE:
  - `done`=1, `core_resetn`=0 (core frozen), `running`=0.
  - `status`, `cycle_count` and `retry_count` are held.
  - `start`=1: go to HOLD, clear `status`, `retry_count`, `cycle_count` and `done`.
- Priority on a single edge: abort > trap > timeout.
  - Abort in HOLD or RUN: go to DONE, `status`=11.
  - Trap on the timeout cycle is reported as trap (or retried).
- `start` is ignored in HOLD and RUN.
- `abort` is ignored in IDLE and DONE.
- `retry_count` saturates at MAX_RETRIES.
- No counter wraps; a parameter check (elaboration error) rejects TIMEOUT_CYCLES >= 2^CNT_W.
- `resetn` asserted mid-operation: everything returns immediately (asynchronously) to reset values, and `core_resetn` drops at once.

Test Plan:
1. AUTO_START=1, RST_CYCLES=2, TIMEOUT_CYCLES=8, `trap`=0, release `resetn` at edge 0:
   - `core_resetn` low edges 1-2, high from edge 3.
   - `done`=1, `status`=10 at edge 11.
   - `cycle_count`=7.
2. Same config, `trap` pulsed in the 5th RUN cycle:
   - DONE at that edge, `status`=01, `cycle_count`=4.
   - `core_resetn`=0 from the next cycle.
3. MAX_RETRIES=2, `trap` pulsed once per run in RUN cycle 3:
   - Two HOLD re-entries.
   - Final `retry_count`=2, `status`=01.
   - `core_resetn` low for exactly RST_CYCLES before each re-run.
4. `abort` and `trap` asserted together in RUN:
   - `status`=11.
   - `abort` asserted in HOLD: DONE next edge, `status`=11, core never released.
5. AUTO_START=0:
   - Stays in IDLE with `core_resetn`=0 for 20 cycles.
   - `start` pulse leads to a normal run.
   - `start` in DONE clears `status` to 00 and re-runs.
   - `start` in RUN has no effect.
6. `resetn` asserted asynchronously mid-RUN (between edges):
   - All outputs reach reset values before the next edge.
   - Sequence restarts after release.
